// File: rtl/adc_serial.sv
// Multi-cycle slice-serial adder/subtractor with carry-in and a start/busy/done handshake.
// One SLICE-bit chunk is summed per clock; the carry ripples through a register between slices.
module adc_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V,
  output logic             Z
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("adc_serial: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic             c;
  logic [KW-1:0]    k;

  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] r_next;
  logic             last;

  // Current slice sum, and the partial result with this slice merged in.
  always_comb begin
    sum    = {1'b0, a[32'(k)*SLICE +: SLICE]} + {1'b0, b[32'(k)*SLICE +: SLICE]}
             + {{SLICE{1'b0}}, c};
    r_next = r;
    r_next[32'(k)*SLICE +: SLICE] = sum[SLICE-1:0];
    last   = (k == KW'(N-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Co    <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
      a     <= '0;
      b     <= '0;
      r     <= '0;
      c     <= 1'b0;
      k     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is folded into an add of the inverted operand and inverted borrow.
            a     <= A;
            b     <= sub ? ~B : B;
            c     <= sub ? ~C0 : C0;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          r <= r_next;
          c <= sum[SLICE];
          k <= k + 1'b1;
          if (last) begin
            S     <= r_next;
            Co    <= sum[SLICE];
            Z     <= (r_next == '0);
            V     <= (a[WIDTH-1] == b[WIDTH-1]) && (r_next[WIDTH-1] != a[WIDTH-1]);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
